add_arb_seq: RTL and testbench

ADD_ARB_SEQ -- requirements
Module: add_arb_seq

---
 rtl/add_arb_pkg.sv | 14 +
 rtl/add_slice.sv | 14 +
 rtl/add_arb_seq.sv | 154 +++++++++++++++
 tb/tb_add_arb_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// Shared types for the two-requester sequential adder: FSM state encoding and requester IDs.
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/add_slice.sv
// Combinational half-width adder slice with carry in/out; time-shared by add_arb_seq.
module add_slice #(
    parameter int unsigned SW = 16
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

endmodule

// File: rtl/add_arb_seq.sv
// Two-requester W-bit adder computing each sum in two passes through one W/2-bit slice.
// Define ADD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module add_arb_seq
    import add_arb_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id
);

    localparam int unsigned H = W / 2;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_cin;
    logic           r_id;
    logic [H-1:0]   r_lo;
    logic           r_carry;
    logic [W-1:0]   r_sum;
    logic           r_cout;

    logic           w_grant;
    logic           w_idle;
    logic           w_accept;
    logic [H-1:0]   w_sa;
    logic [H-1:0]   w_sb;
    logic           w_scin;
    logic [H-1:0]   w_ssum;
    logic           w_scout;

`ifdef ADD_ARB_RR_EN
    logic r_last;

    always_comb begin
        w_grant = ID_REQ0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = ID_REQ1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ID_REQ1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`else
    always_comb begin
        w_grant = ID_REQ0;
        if (!req0_valid && req1_valid) begin
            w_grant = ID_REQ1;
        end
    end
`endif

    // Ready is gated by rst so it drops immediately while reset is held.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign req0_ready = w_idle && (w_grant == ID_REQ0);
    assign req1_ready = w_idle && (w_grant == ID_REQ1);
    assign w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    assign rsp_valid = (r_state == DONE);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

    always_comb begin
        w_sa   = r_a[H-1:0];
        w_sb   = r_b[H-1:0];
        w_scin = r_cin;
        if (r_state == HIGH) begin
            w_sa   = r_a[W-1:H];
            w_sb   = r_b[W-1:H];
            w_scin = r_carry;
        end
    end

    add_slice #(.SW(H)) u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (w_scin),
        .o_sum  (w_ssum),
        .o_cout (w_scout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOW;
            LOW:     w_next = HIGH;
            HIGH:    w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_id    <= ID_REQ0;
            r_lo    <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= (w_grant == ID_REQ1) ? req1_a   : req0_a;
                r_b   <= (w_grant == ID_REQ1) ? req1_b   : req0_b;
                r_cin <= (w_grant == ID_REQ1) ? req1_cin : req0_cin;
                r_id  <= w_grant;
            end
            if (r_state == LOW) begin
                r_lo    <= w_ssum;
                r_carry <= w_scout;
            end
            if (r_state == HIGH) begin
                r_sum  <= {w_ssum, r_lo};
                r_cout <= w_scout;
            end
        end
    end

endmodule

// File: tb/tb_add_arb_seq.sv
// Directed self-checking bench for add_arb_seq (W=32); expectations follow ADD_ARB_RR_EN if defined.
module tb_add_arb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req1_cin;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout, rsp_id;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] held_sum;

    always #5 clk = ~clk;

    add_arb_seq #(.W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h0000_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Single op from requester 0
        check("op1_ready0", req0_ready, 1);
        check("op1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("op1_low_valid", rsp_valid, 0);
        check("op1_low_ready0", req0_ready, 0);
        tick();
        check("op1_high_valid", rsp_valid, 0);
        tick();
        check("op1_valid", rsp_valid, 1);
        check("op1_sum", rsp_sum, 32'h0001_0000);
        check("op1_cout", rsp_cout, 0);
        check("op1_id", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("op1_released", rsp_valid, 0);

        // Wrap from requester 1, then backpressure
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0; req1_cin = 1'b1;
        #1;
        check("wrap_ready1", req1_ready, 1);
        check("wrap_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        check("wrap_valid", rsp_valid, 1);
        check("wrap_sum", rsp_sum, 32'h0);
        check("wrap_cout", rsp_cout, 1);
        check("wrap_id", rsp_id, 1);
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_cin = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_sum", rsp_sum, 32'h0);
            check("bp_cout", rsp_cout, 1);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_resume_ready0", req0_ready, 1);
        check("bp_resume_valid", rsp_valid, 0);

        // Operand hold: inputs change after the accept edge
        tick();
        req0_a = 32'h7;
        req0_valid = 1'b0;
        tick();
        tick();
        check("hold_valid", rsp_valid, 1);
        check("hold_sum", rsp_sum, 32'h2);
        check("hold_id", rsp_id, 0);
        tick();

        // Reset in HIGH
        req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h1111_1111; req1_cin = 1'b0;
        #1;
        check("rh_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rh_valid_imm", rsp_valid, 0);
        check("rh_sum_imm", rsp_sum, 0);
        check("rh_ready0", req0_ready, 0);
        tick();
        check("rh_valid_hold", rsp_valid, 0);
        rst = 1'b0;

        // Contention right after reset release
        req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd20;  req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200; req1_cin = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            logic exp_id;
`ifdef ADD_ARB_RR_EN
            exp_id = ((k / 4) % 2) == 1;
`else
            exp_id = 1'b0;
`endif
            if (k % 4 == 0) begin
                check("ct_ready0", req0_ready, !exp_id);
                check("ct_ready1", req1_ready, exp_id);
                check("ct_idle_valid", rsp_valid, 0);
            end else begin
                check("ct_busy_ready0", req0_ready, 0);
                check("ct_busy_ready1", req1_ready, 0);
            end
            if (k % 4 == 3) begin
                check("ct_valid", rsp_valid, 1);
                check("ct_id", rsp_id, exp_id);
                check("ct_sum", rsp_sum, exp_id ? 32'd301 : 32'd30);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
